// File: rtl/lock_pkg.sv
// Shared types and constants for the smart-lock serial key path.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEFAULT_CODE_W = 4;

  // Unlock pattern expected by the serial lock detector.
  localparam logic [3:0] LOCK_CODE = 4'b1011;

endpackage

// File: rtl/lock_piso.sv
// Parallel-in/serial-out shift register, MSB first.
// msb_next is the MSB the register will hold after the current edge, so the
// owner can register it as its serial output without an extra cycle of delay.
module lock_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb_next
);

  logic [W-1:0] sr;

  // Load has priority over shift; shifting pulls zeros in from the LSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign msb_next = load  ? din[W-1] :
                    shift ? sr[W-2]  :
                            sr[W-1];

endmodule

// File: rtl/lock_key_tx.sv
// Serial key transmitter: shifts a latched code out MSB-first, then holds the
// line low for a programmable gap, framed by a start/busy/done handshake.
module lock_key_tx
  import lock_pkg::*;
#(
  parameter int CODE_W = DEFAULT_CODE_W,
  parameter int GAP_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  input  logic [GAP_W-1:0]  gap,
  output logic              dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CODE_W);

  state_t             state, state_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic               dout_n, dout_valid_n, busy_n, done_n;
  logic               load, shift, msb_next;

  lock_piso #(
    .W (CODE_W)
  ) u_piso (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .shift    (shift),
    .din      (code),
    .msb_next (msb_next)
  );

  // State, counters and all outputs are registered; reset aborts any frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Next-state logic: accept start in IDLE, count code bits, then count the gap.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    dout_valid_n = 1'b0;
    done_n       = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          load         = 1'b1;
          gap_cnt_n    = gap;
          bit_cnt_n    = CNT_W'(CODE_W - 1);
          dout_valid_n = 1'b1;
          state_n      = SEND;
        end
      end
      SEND: begin
        if (bit_cnt != '0) begin
          shift        = 1'b1;
          bit_cnt_n    = bit_cnt - 1'b1;
          dout_valid_n = 1'b1;
        end else if (gap_cnt != '0) begin
          state_n = GAP;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        gap_cnt_n = gap_cnt - 1'b1;
        // A count of 1 here is the last gap cycle; <= guards a corrupted 0.
        if (gap_cnt <= GAP_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // The line is forced low whenever it does not carry a code bit.
    dout_n = dout_valid_n & msb_next;
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_lock_key_tx.sv
// Scoreboard bench for lock_key_tx: a 4-bit and an 8-bit instance share one
// clock and reset. Each accepted start pushes the expected per-cycle
// {dout, dout_valid, busy, done} trace; monitors pop and compare every cycle,
// expecting an all-zero idle pattern whenever nothing is queued.
module tb_lock_key_tx;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       start4, dout4, dout_valid4, busy4, done4;
  logic [3:0] code4, gap4;
  logic       start8, dout8, dout_valid8, busy8, done8;
  logic [7:0] code8;
  logic [3:0] gap8;

  logic [3:0] exp4_q[$];
  logic [3:0] exp8_q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lock_key_tx #(.CODE_W(4), .GAP_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .code(code4), .gap(gap4),
    .dout(dout4), .dout_valid(dout_valid4), .busy(busy4), .done(done4)
  );

  lock_key_tx #(.CODE_W(8), .GAP_W(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .code(code8), .gap(gap8),
    .dout(dout8), .dout_valid(dout_valid8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected trace of one frame, starting with the cycle after the accept edge.
  task automatic push_frame(input bit wide, input logic [7:0] c, input int g);
    int cw;
    cw = wide ? 8 : 4;
    for (int i = cw - 1; i >= 0; i--) begin
      if (wide) exp8_q.push_back({c[i], 1'b1, 1'b1, 1'b0});
      else      exp4_q.push_back({c[i], 1'b1, 1'b1, 1'b0});
    end
    for (int i = 0; i < g; i++) begin
      if (wide) exp8_q.push_back(4'b0010);
      else      exp4_q.push_back(4'b0010);
    end
    if (wide) exp8_q.push_back(4'b0001);
    else      exp4_q.push_back(4'b0001);
  endtask

  // Single start pulse; inputs are scrambled after acceptance.
  task automatic send(input bit wide, input logic [7:0] c, input int g);
    @(posedge clk); #1;
    if (wide) begin code8 = c; gap8 = 4'(g); start8 = 1'b1; end
    else      begin code4 = c[3:0]; gap4 = 4'(g); start4 = 1'b1; end
    @(posedge clk); #1;
    push_frame(wide, c, g);
    if (wide) begin start8 = 1'b0; code8 = ~c; gap8 = 4'hF; end
    else      begin start4 = 1'b0; code4 = ~c[3:0]; gap4 = 4'hF; end
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    e = (exp4_q.size() != 0) ? exp4_q.pop_front() : 4'b0000;
    check("w4_out", {dout4, dout_valid4, busy4, done4}, e);
  end

  always @(negedge clk) begin
    logic [3:0] e;
    e = (exp8_q.size() != 0) ? exp8_q.pop_front() : 4'b0000;
    check("w8_out", {dout8, dout_valid8, busy8, done8}, e);
  end

  initial begin
    reset_n = 1'b0;
    start4 = 1'b0; code4 = '0; gap4 = '0;
    start8 = 1'b0; code8 = '0; gap8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state4", {dout4, dout_valid4, busy4, done4}, 4'b0000);
    check("rst_state8", {dout8, dout_valid8, busy8, done8}, 4'b0000);
    @(negedge clk); #2;
    reset_n = 1'b1;

    // Basic frame with the unlock pattern and a two-cycle gap.
    send(1'b0, {4'b0, LOCK_CODE}, 2);
    repeat (10) @(posedge clk);

    // Zero gap with start held: three frames, 5-cycle period.
    @(posedge clk); #1;
    code4 = LOCK_CODE; gap4 = 4'd0; start4 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push_frame(1'b0, {4'b0, LOCK_CODE}, 0);
    repeat (14) @(posedge clk);
    #1 start4 = 1'b0;
    repeat (10) @(posedge clk);

    // Start and code change while busy must not disturb or extend the frame.
    @(posedge clk); #1;
    code4 = 4'b1100; gap4 = 4'd1; start4 = 1'b1;
    @(posedge clk); #1;
    push_frame(1'b0, 8'h0C, 1);
    start4 = 1'b0; code4 = 4'b0011; gap4 = 4'd3;
    @(posedge clk); #1;
    start4 = 1'b1;
    repeat (2) @(posedge clk);
    #1 start4 = 1'b0;
    repeat (10) @(posedge clk);

    // Asynchronous reset during the second code bit.
    send(1'b0, {4'b0, LOCK_CODE}, 2);
    @(posedge clk); #2;
    reset_n = 1'b0;
    exp4_q.delete();
    #1;
    check("rst_async", {dout4, dout_valid4, busy4, done4}, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);

    // Recovery frame, then a few random frames.
    send(1'b0, 8'h06, 3);
    repeat (10) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] rc;
      int         rg;
      rc = 4'($urandom_range(0, 15));
      rg = $urandom_range(0, 3);
      send(1'b0, {4'b0, rc}, rg);
      repeat (4 + rg + 1) @(posedge clk);
    end
    repeat (4) @(posedge clk);

    // Wide code and maximum gap, then a minimal gap.
    send(1'b1, 8'h81, 15);
    repeat (30) @(posedge clk);
    send(1'b1, 8'hA5, 1);
    repeat (14) @(posedge clk);

    check("q4_drained", exp4_q.size(), 0);
    check("q8_drained", exp8_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_key_tx.md
Name: lock_key_tx

Overview:
Serial key transmitter for the smart-lock datapath. It takes a parallel unlock code and shifts it out MSB-first, one bit per clock, on a single-bit line toward the serial lock detector. After the code it drives a programmable low gap so the detector returns to its idle state. A start/busy/done handshake with the controlling logic frames each transmission.

Parameters:
CODE_W, 4, width of the unlock code in bits (minimum 2)
GAP_W, 4, width of the gap-length input and internal gap counter

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request to transmit; sampled only in IDLE
code  input  CODE_W  code to send; latched on the accepted start edge
gap  input  GAP_W  number of low idle cycles after the code; latched with code
dout  output  1  serial data toward the lock; registered
dout_valid  output  1  high while dout carries a code bit; registered
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse when a frame (code plus gap) completes

Behaviour:
- Reset (reset_n low, asynchronous): state is IDLE; dout, dout_valid, busy and done are 0; shift register, bit counter and gap counter are 0. An active reset aborts any frame in progress immediately, with no done pulse.
- States: IDLE, SEND, GAP.
- IDLE:
  - dout=0, dout_valid=0.
  - On a clock edge with start=1:
    - latch code into shift register and gap into gap counter
    - dout<=code[CODE_W-1], dout_valid<=1
    - bit counter<=CODE_W-1
    - go to SEND
- SEND:
  - Each edge with bit counter != 0: shift left, dout<=next bit, decrement counter.
  - Edge with bit counter == 0: dout<=0, dout_valid<=0.
    - If latched gap != 0: go to GAP.
    - If latched gap == 0: go to IDLE and set done<=1.
- GAP:
  - dout=0, dout_valid=0.
  - Gap counter decrements each edge.
  - Edge where the counter reaches 1: go to IDLE, done<=1.
  - GAP therefore lasts exactly gap cycles.
- Timing, with the start accepted at edge 0:
  - code bits are valid in the CODE_W cycles following edges 0..CODE_W-1
  - done is high in the cycle following edge CODE_W+gap
  - busy is high from edge 0 until edge CODE_W+gap
- done is registered and high for exactly one cycle; it is cleared on the next edge.
- Back-to-back frames: start=1 during the done cycle is accepted, since the state is already IDLE. The new frame's first bit follows that edge with no extra bubble.
- start while busy is ignored and not queued.
- code and gap changes after acceptance do not affect the frame in flight.
- dout is always 0 when dout_valid=0.

Decomposition:
- Shared package lock_pkg:
  - state enum (IDLE, SEND, GAP)
  - default CODE_W
  - constant LOCK_CODE = 4'b1011 (the unlock pattern)
- One sub-module, lock_piso: a parameterised parallel-in/serial-out shift register with load, shift enable and MSB output. lock_key_tx instantiates it and keeps the FSM and counters.

Test Plan:
- Basic frame: reset, code=4'b1011, gap=2, start pulse at edge 0 -> dout/valid sequence 1,0,1,1 (valid=1), then two cycles of dout=0/valid=0; done=1 for one cycle after edge 6; busy high for edges 0-6.
- Zero gap, back-to-back: code=4'b1011, gap=0, start held high continuously -> frames repeat every 5 cycles (4 valid bits, done cycle acts as restart); dout 1,0,1,1 each frame; done pulses every 5 cycles.
- Start during busy and code change: start at edge 0 with code=4'b1100; at edge 2 drive start=1, code=4'b0011 -> dout still 1,1,0,0; no second frame begins until IDLE.
- Reset mid-frame: assert reset_n=0 during the second bit -> dout, dout_valid, busy and done go 0 immediately (asynchronously); after release, the block stays idle until the next start.
- Width/gap extremes: CODE_W=8, code=8'h81, gap=15 -> valid bits 1,0,0,0,0,0,0,1, then 15 low cycles; done after edge 23.
